// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmitter and its baud generator.
`ifndef Tx_CLKRATE
`define Tx_CLKRATE 1_000_000
`endif
`ifndef BAUD
`define BAUD 9600
`endif
`ifndef WORD_LENGTH
`define WORD_LENGTH 8
`endif

package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   function automatic int baud_div(input int clkrate, input int baud);
      return clkrate / baud;
   endfunction

   // Counter width that never collapses to zero bits for tiny ranges.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-word valid/ready handshake feeding the UART transmitter.
interface uart_tx_if #(
   parameter int WORD_LENGTH = 8
);
   logic [WORD_LENGTH-1:0] tx_data;
   logic                   tx_valid;
   logic                   tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter; bit_done marks the last cycle of each bit.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = 104
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   output logic bit_done_o
);
   localparam int            CW   = cnt_width(BAUD_DIV);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] count_q, count_d;

   assign bit_done_o = (count_q == LAST);

   always_comb begin
      count_d = count_q + CW'(1);
      if (clear_i || bit_done_o) count_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: holding register, shift register and frame FSM
// producing start, LSB-first data, optional parity and stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKRATE     = `Tx_CLKRATE,
   parameter int BAUD        = `BAUD,
   parameter int WORD_LENGTH = `WORD_LENGTH,
   parameter bit PARITY_EN   = 1'b1,
   parameter bit PARITY_ODD  = 1'b0
) (
   input  logic      t_clk,
   input  logic      t_rst,
   uart_tx_if.slave  tx_if,
   output logic      tx_busy,
   output logic      UART_Tx_OUT
);
   localparam int            BAUD_DIV = baud_div(CLKRATE, BAUD);
   localparam int            IW       = cnt_width(WORD_LENGTH);
   localparam logic [IW-1:0] LAST_BIT = IW'(WORD_LENGTH - 1);

   tx_state_t              state_q, state_d;
   logic [WORD_LENGTH-1:0] shift_q, shift_d;
   logic [WORD_LENGTH-1:0] hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   parity_q, parity_d;
   logic                   line_q, line_d;
   logic                   bit_done, accept, load;

   // Counter sits at zero while idle so the start bit gets a full period.
   uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk       (t_clk),
      .rst_n     (t_rst),
      .clear_i   (state_q == IDLE),
      .bit_done_o(bit_done)
   );

   assign accept         = tx_if.tx_valid && !hold_full_q;
   assign tx_if.tx_ready = !hold_full_q;
   assign tx_busy        = (state_q != IDLE);
   assign UART_Tx_OUT    = line_q;

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d     = state_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      parity_d    = parity_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      line_d      = 1'b1;
      load        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               load    = 1'b1;
               state_d = START;
            end
         end
         START: begin
            line_d = 1'b0;
            if (bit_done) state_d = DATA;
         end
         DATA: begin
            line_d = shift_q[0];
            if (bit_done) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + IW'(1);
               if (idx_q == LAST_BIT) begin
                  idx_d   = '0;
                  state_d = PARITY_EN ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            line_d = parity_q;
            if (bit_done) state_d = STOP;
         end
         STOP: begin
            // A waiting word chains straight into the next start bit.
            if (bit_done) begin
               if (hold_full_q) begin
                  load    = 1'b1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         shift_d     = hold_q;
         idx_d       = '0;
         parity_d    = (^hold_q) ^ PARITY_ODD;
         hold_full_d = 1'b0;
      end
      if (accept) begin
         hold_d      = tx_if.tx_data;
         hold_full_d = 1'b1;
      end
   end

   // NOTE: state uses non-blocking assignments so all registers update together.
   always_ff @(posedge t_clk or negedge t_rst) begin
      if (!t_rst) begin
         // NOTE: data registers are reset too so a stale word can never leak out.
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         idx_q       <= '0;
         parity_q    <= 1'b0;
         line_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         idx_q       <= idx_d;
         parity_q    <= parity_d;
         line_q      <= line_d;
      end
   end
endmodule
